// File: rtl/keypad_msg_ctrl.sv
// Keypad-to-UART message framer: collects ASCII digits from key presses and
// emits STX, the digits in order, then ETX over a valid/ready byte stream.
module keypad_msg_ctrl #(
  parameter int MAX_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] key_data,
  input  logic       key_start,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       busy,
  output logic [3:0] digit_count,
  output logic       overflow
);

  localparam int             TW         = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]     LAST_DIGIT = 4'(MAX_DIGITS - 1);
  localparam logic [7:0]     STX        = 8'h02;
  localparam logic [7:0]     ETX        = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_SEND_STX,
    S_SEND_DATA,
    S_SEND_ETX
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [3:0]    index;
  logic          key_start_d;
  logic [7:0]    digit_buf [16];

  logic digit_press;
  logic accept;
  logic handshake;

  // A press is the rising edge of key_start; only ASCII '0'..'9' counts.
  assign digit_press = key_start && !key_start_d && (key_data >= 8'h30) && (key_data <= 8'h39);
  assign accept      = digit_press && ((state == S_IDLE) || (state == S_COLLECT));
  // A byte transfers on any edge where tx_valid and tx_ready are both high;
  // tx_valid and tx_data hold steady until that edge.
  assign handshake   = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      digit_buf[digit_count] <= key_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      tx_data     <= 8'h00;
      tx_valid    <= 1'b0;
      busy        <= 1'b0;
      digit_count <= 4'd0;
      overflow    <= 1'b0;
      timer       <= '0;
      index       <= 4'd0;
      key_start_d <= 1'b0;
    end else begin
      key_start_d <= key_start;
      case (state)
        S_IDLE, S_COLLECT: begin
          if (accept) begin
            digit_count <= digit_count + 4'd1;
            timer       <= '0;
            if (digit_count == LAST_DIGIT) begin
              state    <= S_SEND_STX;
              tx_data  <= STX;
              tx_valid <= 1'b1;
              busy     <= 1'b1;
            end else begin
              state <= S_COLLECT;
            end
          end else if (state == S_COLLECT) begin
            // An accept on the timeout cycle takes the branch above instead.
            if (timer == TIMER_LAST) begin
              state    <= S_SEND_STX;
              tx_data  <= STX;
              tx_valid <= 1'b1;
              busy     <= 1'b1;
              timer    <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        S_SEND_STX: begin
          if (handshake) begin
            state   <= S_SEND_DATA;
            index   <= 4'd0;
            tx_data <= digit_buf[0];
          end
        end
        S_SEND_DATA: begin
          if (handshake) begin
            if (index == digit_count - 4'd1) begin
              state   <= S_SEND_ETX;
              tx_data <= ETX;
            end else begin
              index   <= index + 4'd1;
              tx_data <= digit_buf[index + 4'd1];
            end
          end
        end
        S_SEND_ETX: begin
          if (handshake) begin
            state       <= S_IDLE;
            tx_valid    <= 1'b0;
            tx_data     <= 8'h00;
            busy        <= 1'b0;
            digit_count <= 4'd0;
          end
        end
        default: state <= S_IDLE;
      endcase
      // Presses arriving mid-frame are lost; remember that it happened.
      if (digit_press && busy) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_keypad_msg_ctrl.sv
// Bench for keypad_msg_ctrl: scenario tasks plus a per-cycle queue-based
// reference model of message framing and a byte scoreboard.
module tb_keypad_msg_ctrl;

  localparam int MAXD = 4;
  localparam int TO   = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] key_data;
  logic       key_start;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;
  logic [3:0] digit_count;
  logic       overflow;

  keypad_msg_ctrl #(.MAX_DIGITS(MAXD), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .key_data(key_data), .key_start(key_start),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy),
    .digit_count(digit_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: digits waiting for a frame, bytes of the frame in flight.
  logic [7:0] exp_q[$];
  logic [7:0] pend[$];
  logic [7:0] log_q[$];
  int         cyc_q[$];
  int         m_frame_left = 0;
  int         m_frame_n    = 0;
  int         m_idle       = 0;
  bit         m_key_prev   = 0;
  bit         m_ovf        = 0;

  bit         checks_on  = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_data;
  bit         bp_mode    = 0;
  bit         rnd_ready  = 0;

  task automatic launch();
    exp_q.push_back(8'h02);
    foreach (pend[i]) exp_q.push_back(pend[i]);
    exp_q.push_back(8'h03);
    m_frame_left = pend.size() + 2;
    m_frame_n    = pend.size();
    pend.delete();
    m_idle = 0;
  endtask

  task automatic step();
    logic [7:0] e;
    int         exp_cnt;
    bit         dp;
    @(negedge clk);
    cyc++;
    exp_cnt = (m_frame_left > 0) ? m_frame_n : pend.size();
    if (checks_on) begin
      total++;
      if (tx_valid !== (m_frame_left > 0)) begin
        bad++; $display("FAIL tx_valid cyc=%0d got=%b exp=%b", cyc, tx_valid, m_frame_left > 0);
      end
      total++;
      if (busy !== (m_frame_left > 0)) begin
        bad++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, m_frame_left > 0);
      end
      total++;
      if (digit_count !== 4'(exp_cnt)) begin
        bad++; $display("FAIL digit_count cyc=%0d got=%0d exp=%0d", cyc, digit_count, exp_cnt);
      end
      total++;
      if (overflow !== m_ovf) begin
        bad++; $display("FAIL overflow cyc=%0d got=%b exp=%b", cyc, overflow, m_ovf);
      end
      if (prev_stall) begin
        total++;
        if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
          bad++; $display("FAIL stall_hold cyc=%0d got=%h/%b exp=%h/1", cyc, tx_data, tx_valid, prev_data);
        end
      end
      if (tx_valid === 1'b1 && tx_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL unexpected_byte cyc=%0d got=%h exp=none", cyc, tx_data);
        end else begin
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            bad++; $display("FAIL byte cyc=%0d got=%h exp=%h", cyc, tx_data, e);
          end
        end
        log_q.push_back(tx_data);
        cyc_q.push_back(cyc);
      end
    end
    prev_stall = (tx_valid === 1'b1) && !tx_ready;
    prev_data  = tx_data;
    // Advance the model to what the coming edge should produce.
    if (reset) begin
      exp_q.delete(); pend.delete();
      m_frame_left = 0; m_frame_n = 0; m_idle = 0; m_key_prev = 0; m_ovf = 0;
      prev_stall = 0;
    end else begin
      dp = key_start && !m_key_prev && key_data >= 8'h30 && key_data <= 8'h39;
      if (m_frame_left > 0) begin
        if (tx_ready) m_frame_left--;
        if (dp) m_ovf = 1;
      end else if (dp) begin
        pend.push_back(key_data);
        m_idle = 0;
        if (pend.size() == MAXD) launch();
      end else if (pend.size() > 0) begin
        if (m_idle == TO - 1) launch();
        else m_idle++;
      end
      m_key_prev = key_start;
    end
    @(posedge clk);
    #1;
    if (bp_mode) tx_ready = ~tx_ready;
    else if (rnd_ready) tx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic press(input logic [7:0] d, input int hold, input int gap);
    key_data  = d;
    key_start = 1'b1;
    repeat (hold) step();
    key_start = 1'b0;
    key_data  = 8'h00;
    repeat (gap) step();
  endtask

  task automatic drain(input string name, input int max_cycles);
    int n = 0;
    while ((m_frame_left > 0 || pend.size() > 0) && n < max_cycles) begin
      step();
      n++;
    end
    total++;
    if (m_frame_left > 0 || pend.size() > 0) begin
      bad++; $display("FAIL %s_drain got=still_open exp=done_within_%0d", name, max_cycles);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; key_start = 1'b0; key_data = 8'h00; tx_ready = 1'b0;
    step();
    checks_on = 1;
    step(); step();
    total++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || digit_count !== 4'd0 || overflow !== 1'b0 || tx_data !== 8'h00) begin
      bad++; $display("FAIL reset_state got=v%b b%b c%0d o%b d%h exp=all_zero", tx_valid, busy, digit_count, overflow, tx_data);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_full_frame();
    logic [7:0] want[$];
    want = '{8'h02, 8'h31, 8'h32, 8'h33, 8'h34, 8'h03};
    tx_ready = 1'b1; log_q.delete(); cyc_q.delete();
    for (int i = 0; i < 4; i++) press(8'h31 + 8'(i), 5, 3);
    drain("full_frame", 100);
    step();
    for (int i = 0; i < 6; i++) begin
      total++;
      if (i >= log_q.size() || log_q[i] !== want[i] || cyc_q[i] !== cyc_q[0] + i) begin
        bad++; $display("FAIL full_frame_byte%0d got=%h exp=%h (consecutive)", i, (i < log_q.size()) ? log_q[i] : 8'hxx, want[i]);
      end
    end
    total++;
    if (log_q.size() != 6 || tx_valid !== 1'b0 || digit_count !== 4'd0) begin
      bad++; $display("FAIL full_frame_end got=n%0d v%b c%0d exp=n6 v0 c0", log_q.size(), tx_valid, digit_count);
    end
  endtask

  task automatic test_timeout();
    int p;
    tx_ready = 1'b1; log_q.delete(); cyc_q.delete();
    press(8'h37, 1, 0);
    p = cyc;
    repeat (19) step();
    total++;
    if (log_q.size() != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL timeout_early got=n%0d busy%b exp=n0 busy0", log_q.size(), busy);
    end
    drain("timeout", 40);
    total++;
    if (log_q.size() != 3 || log_q[0] !== 8'h02 || log_q[1] !== 8'h37 || log_q[2] !== 8'h03 || cyc_q[0] - p != TO + 1) begin
      bad++; $display("FAIL timeout_frame got=n%0d start+%0d exp=02,37,03 start+%0d", log_q.size(), (cyc_q.size() > 0) ? cyc_q[0] - p : -1, TO + 1);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] want[$];
    want = '{8'h02, 8'h39, 8'h30, 8'h35, 8'h35, 8'h03};
    log_q.delete(); cyc_q.delete();
    tx_ready = 1'b1; bp_mode = 1;
    press(8'h39, 2, 1); press(8'h30, 2, 1); press(8'h35, 2, 1); press(8'h35, 2, 1);
    drain("backpressure", 60);
    bp_mode = 0; tx_ready = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      total++;
      if (i >= log_q.size() || log_q[i] !== want[i]) begin
        bad++; $display("FAIL backpressure_byte%0d got=%h exp=%h", i, (i < log_q.size()) ? log_q[i] : 8'hxx, want[i]);
      end
    end
  endtask

  task automatic test_held_nondigit();
    log_q.delete(); cyc_q.delete();
    tx_ready = 1'b1;
    key_data = 8'h33; key_start = 1'b1;
    repeat (10) step();
    total++;
    if (digit_count !== 4'd1 || overflow !== 1'b0) begin
      bad++; $display("FAIL held_key got=c%0d o%b exp=c1 o0", digit_count, overflow);
    end
    repeat (90) step();
    press(8'h00, 3, 3);
    drain("held", 40);
    total++;
    if (log_q.size() != 3 || log_q[1] !== 8'h33 || overflow !== 1'b0 || digit_count !== 4'd0) begin
      bad++; $display("FAIL held_frame got=n%0d o%b c%0d exp=n3 o0 c0", log_q.size(), overflow, digit_count);
    end
  endtask

  task automatic test_drop_and_boundary();
    logic [7:0] d[4];
    logic [7:0] a, b;
    log_q.delete(); cyc_q.delete();
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d[i] = 8'h30 + 8'($urandom_range(0, 9));
      press(d[i], 1, 1);
    end
    press(8'h38, 2, 2);
    total++;
    if (overflow !== 1'b1 || busy !== 1'b1 || digit_count !== 4'd4) begin
      bad++; $display("FAIL drop_busy got=o%b b%b c%0d exp=o1 b1 c4", overflow, busy, digit_count);
    end
    tx_ready = 1'b1;
    drain("drop", 20);
    total++;
    if (log_q.size() != 6 || log_q[1] !== d[0] || log_q[2] !== d[1] || log_q[3] !== d[2] || log_q[4] !== d[3]) begin
      bad++; $display("FAIL drop_frame got=n%0d exp=n6 digits %h%h%h%h", log_q.size(), d[0], d[1], d[2], d[3]);
    end
    log_q.delete(); cyc_q.delete();
    a = 8'h30 + 8'($urandom_range(0, 9));
    b = 8'h30 + 8'($urandom_range(0, 9));
    press(a, 1, 0);
    repeat (TO - 1) step();
    key_data = b; key_start = 1'b1;
    step();
    key_data = 8'h00; key_start = 1'b0;
    total++;
    if (digit_count !== 4'd2 || busy !== 1'b0 || log_q.size() != 0) begin
      bad++; $display("FAIL timeout_accept got=c%0d b%b n%0d exp=c2 b0 n0", digit_count, busy, log_q.size());
    end
    repeat (TO - 1) step();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL timer_restart got=b%b exp=b0", busy);
    end
    drain("boundary", 10);
    step();
    total++;
    if (log_q.size() != 4 || log_q[1] !== a || log_q[2] !== b || log_q[3] !== 8'h03) begin
      bad++; $display("FAIL boundary_frame got=n%0d exp=02,%h,%h,03", log_q.size(), a, b);
    end
  endtask

  task automatic test_midframe_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) press(8'h30 + 8'($urandom_range(0, 9)), 1, 1);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    step(); step();
    total++;
    if (busy !== 1'b1 || tx_valid !== 1'b1) begin
      bad++; $display("FAIL pre_reset got=b%b v%b exp=b1 v1", busy, tx_valid);
    end
    reset = 1'b1;
    step();
    total++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || digit_count !== 4'd0 || overflow !== 1'b0) begin
      bad++; $display("FAIL midframe_reset got=v%b b%b c%0d o%b exp=0000", tx_valid, busy, digit_count, overflow);
    end
    reset = 1'b0;
    tx_ready = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_random();
    logic [7:0] d;
    rnd_ready = 1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) d = 8'($urandom_range(0, 255));
      else d = 8'h30 + 8'($urandom_range(0, 9));
      press(d, $urandom_range(1, 4), $urandom_range(0, 25));
    end
    drain("random", 400);
    rnd_ready = 0; tx_ready = 1'b1;
    repeat (3) step();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL random_leftover got=%0d exp=0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_timeout();
    test_backpressure();
    test_held_nondigit();
    test_drop_and_boundary();
    test_midframe_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_msg_ctrl.md
Name: keypad_msg_ctrl

Overview:
Sequences keypad key codes into framed messages for the UART transmitter. It edge-detects the key strobe from the keypad decoder, buffers ASCII digits, and closes a message when the buffer fills or the keypad goes idle. It then sends STX (0x02), the buffered digits in order, and ETX (0x03) over a valid/ready byte interface. It sits between the keypad decoder and the UART TX block.

Parameters:
MAX_DIGITS, 4, digit buffer depth; a message closes when this many digits are held (range 1..15)
TIMEOUT_CYCLES, 50_000_000, idle clock cycles after the last accepted digit before a partial message is sent (1 s at 50 MHz); must be >= 2

Ports:
clk  in  1  system clock; the only clock
reset  in  1  synchronous, active-high reset
key_data  in  8  ASCII code from the keypad decoder; 0x00 when no key
key_start  in  1  level, high while a key is held
tx_ready  in  1  UART TX can accept a byte this cycle
tx_data  out  8  byte offered to the UART
tx_valid  out  1  tx_data is valid; held until accepted
busy  out  1  high in any SEND_* state
digit_count  out  4  number of digits currently buffered
overflow  out  1  sticky; set when a key is dropped, cleared only by reset

Behaviour:
- Reset: state IDLE, tx_data=0x00, tx_valid=0, busy=0, digit_count=0, overflow=0, timer=0, key_start_d=0. Reset wins over every other event in any state, including mid-frame. Any partial frame is abandoned.
- key_start_d is key_start registered once. A press is a cycle with key_start=1 and key_start_d=0.
- A press is a digit only if key_data is in 0x30..0x39. Presses with other values are ignored and do not set overflow. A held key produces exactly one press.
- Accept: in IDLE or COLLECT, on a digit press, write key_data to buf[digit_count] and increment digit_count at that clock edge. IDLE moves to COLLECT. Timer clears to 0.
- COLLECT: the timer increments each cycle with no accept.
  - If timer == TIMEOUT_CYCLES-1 and no accept, go to SEND_STX.
  - If an accept and the timeout fall in the same cycle, the accept wins: the digit is stored, the timer restarts, and the message stays open.
- Full: on the edge that writes digit number MAX_DIGITS, go directly to SEND_STX.
- SEND_STX: tx_data=0x02, tx_valid=1. On tx_valid & tx_ready, go to SEND_DATA with index=0.
- SEND_DATA: tx_data=buf[index], tx_valid=1. On a handshake, index increments. After the handshake on index==digit_count-1, go to SEND_ETX.
- SEND_ETX: tx_data=0x03, tx_valid=1. On a handshake, go to IDLE, clear digit_count, and drop tx_valid the next cycle.
- tx_valid and tx_data are registered. Each byte is presented the cycle after the state is entered or the previous handshake completes. The earliest byte rate is one byte every cycle when tx_ready is held at 1. tx_data never changes while tx_valid=1 and tx_ready=0.
- Digit presses in any SEND_* state are dropped and set overflow. The buffer and frame are unaffected.
- Frames are never empty: SEND_STX is only reachable with digit_count >= 1.
- busy=1 exactly while the state is SEND_STX, SEND_DATA or SEND_ETX.

Test Plan:
- Reset mid-frame: assert reset during SEND_DATA with tx_ready=0 -> next cycle tx_valid=0, busy=0, digit_count=0, overflow=0, state IDLE.
- Full frame: MAX_DIGITS=4, tx_ready=1; press '1','2','3','4' (0x31..0x34), each held 5 cycles with 3 idle cycles between -> the tx stream is exactly 0x02,0x31,0x32,0x33,0x34,0x03 on consecutive cycles, then tx_valid=0 and digit_count=0.
- Timeout: TIMEOUT_CYCLES=20; press '7' once -> after 20 idle cycles the stream is 0x02,0x37,0x03; no bytes appear before the timeout.
- Backpressure: full frame of '9','0','5','5' with tx_ready toggling 1/0 every cycle -> the same 6-byte sequence, tx_data stable whenever tx_valid=1 and tx_ready=0, and no byte duplicated or skipped.
- Held key and non-digit: hold '3' for 100 cycles, then press key_data=0x00 -> digit_count=1 and overflow=0.
- Drop during send and boundary: press '8' while busy -> overflow=1, the frame is unchanged. Then, with TIMEOUT_CYCLES=20, accept a digit on the exact timeout cycle -> no frame starts, digit_count increments, and the timer restarts.
